// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared next-PC select codes and default vectors
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_RET,
    SEL_JMP,
    SEL_EXC
  } pc_sel_e;

  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_VECTOR   = 32'h0000_0180;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; a push while full overwrites the oldest entry
module pc_ras #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_sp;
  logic [AW:0]      r_count;
  logic [AW-1:0]    w_top_idx;
  logic             w_do_push;
  logic             w_do_pop;

  // r_sp is the next write slot; when full it also points at the oldest entry
  assign w_top_idx = r_sp - AW'(1);
  assign top       = r_mem[w_top_idx];
  assign count     = r_count;
  assign full      = (r_count == FULL_COUNT);
  assign empty     = (r_count == '0);
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & ~pop;
  assign overflow  = w_do_push & full;
  assign underflow = pop & empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sp    <= '0;
      r_count <= '0;
    end else if (w_do_pop) begin
      r_sp    <= w_top_idx;
      r_count <= r_count - (AW+1)'(1);
    end else if (w_do_push) begin
      r_sp <= r_sp + AW'(1);
      if (!full) r_count <= r_count + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_sp] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - prioritised next-PC selection with exception capture and return-address stack
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(PC_EXC_VECTOR),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       exception,
  input  logic                       branch_taken,
  input  logic [WIDTH-1:0]           branch_target,
  input  logic                       jump,
  input  logic [WIDTH-1:0]           jump_target,
  input  logic                       call,
  input  logic                       ret,
  input  logic [WIDTH-1:0]           reg_target,
  output logic [WIDTH-1:0]           current_pc,
  output logic [WIDTH-1:0]           pc_plus4,
  output logic [WIDTH-1:0]           epc,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_empty,
  output logic                       ras_full,
  output logic                       ras_err
);

  pc_sel_e          w_sel;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_next_pc;
  logic [WIDTH-1:0] w_ras_top;
  logic             w_push;
  logic             w_pop;
  logic             w_overflow;
  logic             w_underflow;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic             r_err;

  assign pc_plus4 = r_pc + WIDTH'(4);

  always_comb begin
    w_sel = SEL_SEQ;
    if (exception)         w_sel = SEL_EXC;
    else if (branch_taken) w_sel = SEL_BR;
    else if (ret)          w_sel = SEL_RET;
    else if (jump)         w_sel = SEL_JMP;
  end

  always_comb begin
    w_target = pc_plus4;
    case (w_sel)
      SEL_EXC: w_target = EXC_VECTOR;
      SEL_BR:  w_target = branch_target;
      SEL_RET: w_target = ras_empty ? reg_target : w_ras_top;
      SEL_JMP: w_target = jump_target;
      default: w_target = pc_plus4;
    endcase
  end

  assign w_next_pc = {w_target[WIDTH-1:2], 2'b00};

  // RAS only moves on an unstalled ret/call win; exceptions and branches leave it alone
  assign w_push = ~stall & (w_sel == SEL_JMP) & call;
  assign w_pop  = ~stall & (w_sel == SEL_RET);

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (pc_plus4),
    .top       (w_ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty),
    .overflow  (w_overflow),
    .underflow (w_underflow)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc  <= RESET_VECTOR;
      r_epc <= '0;
      r_err <= 1'b0;
    end else begin
      if (exception || !stall) r_pc <= w_next_pc;
      if (exception) r_epc <= r_pc;
      if (w_overflow || w_underflow) r_err <= 1'b1;
    end
  end

  assign current_pc = r_pc;
  assign epc        = r_epc;
  assign ras_err    = r_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        exception;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        call;
  logic        ret;
  logic [31:0] reg_target;
  logic [31:0] current_pc;
  logic [31:0] pc_plus4;
  logic [31:0] epc;
  logic [2:0]  ras_count;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [2:0]  cnt;
    logic        err;
  } exp_t;

  exp_t sb[$];

  pc_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .exception     (exception),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .call          (call),
    .ret           (ret),
    .reg_target    (reg_target),
    .current_pc    (current_pc),
    .pc_plus4      (pc_plus4),
    .epc           (epc),
    .ras_count     (ras_count),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_err       (ras_err)
  );

  always #5 clock = ~clock;

  task automatic drive(input logic bt, input logic [31:0] bta, input logic j, input logic c,
                       input logic [31:0] jt, input logic r, input logic [31:0] rt,
                       input logic st, input logic ex);
    branch_taken  = bt;
    branch_target = bta;
    jump          = j;
    call          = c;
    jump_target   = jt;
    ret           = r;
    reg_target    = rt;
    stall         = st;
    exception     = ex;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cycle(input string tag, input logic [31:0] pc, input logic [31:0] e_epc,
                       input logic [2:0] cnt, input logic err);
    exp_t e;
    sb.push_back('{tag, pc, e_epc, cnt, err});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    checks++;
    assert (current_pc === e.pc) else begin
      errors++; $error("FAIL %s current_pc observed=%h expected=%h", e.tag, current_pc, e.pc);
    end
    checks++;
    assert (pc_plus4 === e.pc + 32'd4) else begin
      errors++; $error("FAIL %s pc_plus4 observed=%h expected=%h", e.tag, pc_plus4, e.pc + 32'd4);
    end
    checks++;
    assert (epc === e.epc) else begin
      errors++; $error("FAIL %s epc observed=%h expected=%h", e.tag, epc, e.epc);
    end
    checks++;
    assert (ras_count === e.cnt) else begin
      errors++; $error("FAIL %s ras_count observed=%0d expected=%0d", e.tag, ras_count, e.cnt);
    end
    checks++;
    assert (ras_err === e.err) else begin
      errors++; $error("FAIL %s ras_err observed=%b expected=%b", e.tag, ras_err, e.err);
    end
    checks++;
    assert (ras_empty === (e.cnt == 3'd0)) else begin
      errors++; $error("FAIL %s ras_empty observed=%b expected=%b", e.tag, ras_empty, e.cnt == 3'd0);
    end
    checks++;
    assert (ras_full === (e.cnt == 3'd4)) else begin
      errors++; $error("FAIL %s ras_full observed=%b expected=%b", e.tag, ras_full, e.cnt == 3'd4);
    end
  endtask

  logic [31:0] ret_exp [5];
  logic [2:0]  cnt_exp;

  initial begin
    reset = 1'b1;
    idle();
    #1;
    cycle("reset", 32'h0, 32'h0, 3'd0, 1'b0);
    reset = 1'b0;

    cycle("seq1", 32'h4, 32'h0, 3'd0, 1'b0);
    cycle("seq2", 32'h8, 32'h0, 3'd0, 1'b0);
    cycle("seq3", 32'hC, 32'h0, 3'd0, 1'b0);

    drive(1, 32'h103, 1, 1, 32'h500, 0, 0, 0, 0);
    cycle("br_over_jmp", 32'h100, 32'h0, 3'd0, 1'b0);
    drive(1, 32'h20, 0, 0, 0, 0, 0, 0, 0);
    cycle("br_to_20", 32'h20, 32'h0, 3'd0, 1'b0);

    drive(0, 0, 1, 1, 32'h200, 0, 0, 0, 0);
    cycle("call_200", 32'h200, 32'h0, 3'd1, 1'b0);
    drive(0, 0, 0, 0, 0, 1, 32'h999, 0, 0);
    cycle("ret_24", 32'h24, 32'h0, 3'd0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 1, 32'h300 + 32'(i) * 32'h100, 0, 0, 0, 0);
      cnt_exp = (i < 4) ? 3'(i + 1) : 3'd4;
      cycle($sformatf("call%0d", i), 32'h300 + 32'(i) * 32'h100, 32'h0, cnt_exp, i == 4);
    end

    ret_exp[0] = 32'h604;
    ret_exp[1] = 32'h504;
    ret_exp[2] = 32'h404;
    ret_exp[3] = 32'h304;
    ret_exp[4] = 32'hABC;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 1, 32'h7000, 1, 32'hABF, 0, 0);
      cnt_exp = (i < 4) ? 3'(3 - i) : 3'd0;
      cycle($sformatf("ret%0d", i), ret_exp[i], 32'h0, cnt_exp, 1'b1);
    end

    drive(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    cycle("br_to_40", 32'h40, 32'h0, 3'd0, 1'b1);
    drive(0, 0, 1, 1, 32'h900, 0, 0, 1, 0);
    cycle("stall1", 32'h40, 32'h0, 3'd0, 1'b1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cycle("stall_exc", 32'h180, 32'h40, 3'd0, 1'b1);
    drive(0, 0, 0, 0, 0, 1, 32'h10, 1, 0);
    cycle("stall3", 32'h180, 32'h40, 3'd0, 1'b1);

    drive(0, 0, 1, 1, 32'h800, 0, 0, 0, 0);
    cycle("call_800", 32'h800, 32'h40, 3'd1, 1'b1);

    reset = 1'b1;
    drive(1, 32'h44, 1, 1, 32'h900, 0, 0, 1, 1);
    cycle("mid_reset", 32'h0, 32'h0, 3'd0, 1'b0);
    reset = 1'b0;

    drive(0, 0, 0, 0, 0, 1, 32'h57, 0, 0);
    cycle("ret_empty", 32'h54, 32'h0, 3'd0, 1'b1);
    idle();
    cycle("seq_after", 32'h58, 32'h0, 3'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
